nv_nvdla_sdp_rdma_req_arb: RTL and testbench

Shares one DMA read-request port among the three SDP RDMA sub-engines (BS, BN, EW) with round-robin arbitration. A request is granted only when the shared read-return latency buffer has credit for every atom of that request. The order of grants is recorded in an order FIFO, which the return path pops to route data to the matching per-engine unpacker.

---
 rtl/nv_nvdla_sdp_rdma_pkg.sv | 33 +++
 rtl/nv_nvdla_sdp_rdma_ord_fifo.sv | 54 +++++
 rtl/nv_nvdla_sdp_rdma_req_arb.sv | 183 ++++++++++++++++++
 tb/tb_nv_nvdla_sdp_rdma_req_arb.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_sdp_rdma_pkg.sv
// Shared definitions for the SDP RDMA request path: requester ids,
// request/order payload layouts and round-robin index arithmetic.
package nv_nvdla_sdp_rdma_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] ID_BS = 2'd0;
    localparam logic [1:0] ID_BN = 2'd1;
    localparam logic [1:0] ID_EW = 2'd2;

    localparam int RDMA_AW = 64;
    localparam int RDMA_SW = 15;

    // Request payload as carried on the *_req_pd buses: {size, addr}
    typedef struct packed {
        logic [RDMA_SW-1:0] size;
        logic [RDMA_AW-1:0] addr;
    } rdma_req_pd_t;

    // Order-FIFO entry consumed by the return path: {id, size}
    typedef struct packed {
        logic [1:0]         id;
        logic [RDMA_SW-1:0] size;
    } rdma_ord_pd_t;

    // Requester id offset by 'off' positions, modulo NUM_REQ
    function automatic logic [1:0] rr_add(input logic [1:0] id, input int unsigned off);
        logic [31:0] s;
        s = 32'(id) + off;
        return 2'(s % 32'(NUM_REQ));
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rdma_ord_fifo.sv
// Grant-order FIFO: records which requester was granted so the return
// path can steer read data to the matching unpacker. Head is readable
// combinationally; a pushed entry becomes visible the following cycle.
module nv_nvdla_sdp_rdma_ord_fifo
#(
    parameter int DEPTH = 16,
    parameter int DW    = 17
)(
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          push,
    input  logic [DW-1:0] push_pd,
    input  logic          pop,
    output logic [DW-1:0] pop_pd,
    output logic          full,
    output logic          empty
);

    localparam int PTRW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTRW:0] wr_ptr_reg;
    logic [PTRW:0] rd_ptr_reg;
    logic [DW-1:0] mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTRW] != rd_ptr_reg[PTRW]) &&
                     (wr_ptr_reg[PTRW-1:0] == rd_ptr_reg[PTRW-1:0]);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign pop_pd  = mem[rd_ptr_reg[PTRW-1:0]];

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge nvdla_core_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[PTRW-1:0]] <= push_pd;
        end
    end

    // Pointer advance; pops on an empty FIFO are dropped
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_req_arb.sv
// SDP RDMA read-request arbiter: round-robin across BS/BN/EW, a grant
// needs latency-buffer credit for every atom of the request, and the
// grant order is logged for the return path.
module nv_nvdla_sdp_rdma_req_arb
    import nv_nvdla_sdp_rdma_pkg::*;
#(
    parameter int LAT_DEPTH = 256,
    parameter int ORD_DEPTH = 16,
    parameter int AW        = RDMA_AW,
    parameter int SW        = RDMA_SW,
    localparam int CW       = $clog2(LAT_DEPTH + 1)
)(
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             bs_req_pvld,
    output logic             bs_req_prdy,
    input  logic [AW+SW-1:0] bs_req_pd,
    input  logic             bn_req_pvld,
    output logic             bn_req_prdy,
    input  logic [AW+SW-1:0] bn_req_pd,
    input  logic             ew_req_pvld,
    output logic             ew_req_prdy,
    input  logic [AW+SW-1:0] ew_req_pd,
    output logic             dma_rd_req_pvld,
    input  logic             dma_rd_req_prdy,
    output logic [AW+SW-1:0] dma_rd_req_pd,
    input  logic             lat_pop,
    output logic             ord_pvld,
    input  logic             ord_prdy,
    output logic [2+SW-1:0]  ord_pd,
    output logic [CW-1:0]    credit_cnt
);

    localparam int PW = AW + SW;
    localparam int NW = SW + 1;                          // width of size+1
    localparam int MW = (NW > CW + 1) ? NW : CW + 1;     // credit arithmetic width

    logic [NUM_REQ-1:0] req_vld;
    logic [PW-1:0]      req_pd [NUM_REQ];
    logic [1:0]         cand_id [NUM_REQ];

    logic [1:0]    rr_ptr_reg;
    logic          lock_reg;
    logic [1:0]    locked_id_reg;
    logic          pvld_reg;
    logic [PW-1:0] pd_reg;
    logic [CW-1:0] credit_cnt_reg;
    logic [CW-1:0] credit_next;
    logic [MW-1:0] credit_sum;

    logic [1:0]    sel_id;
    logic          sel_vld;
    logic [1:0]    win_id;
    logic          win_vld;
    logic [PW-1:0] win_pd;
    logic [SW-1:0] win_size;
    logic [NW-1:0] win_need;
    logic          credit_ok;
    logic          out_free;
    logic          ord_full;
    logic          ord_empty;
    logic          grant;

    assign req_vld   = {ew_req_pvld, bn_req_pvld, bs_req_pvld};
    assign req_pd[0] = bs_req_pd;
    assign req_pd[1] = bn_req_pd;
    assign req_pd[2] = ew_req_pd;

    // Candidate order for this cycle: rr_ptr first, then the next ids
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_id[gi] = rr_add(rr_ptr_reg, gi);
    end

    // First valid requester in round-robin order (scan backwards so the earliest wins)
    always_comb begin
        sel_id  = cand_id[0];
        sel_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_vld[cand_id[k]]) begin
                sel_id  = cand_id[k];
                sel_vld = 1'b1;
            end
        end
    end

    // A stalled winner stays locked so large requests can accumulate credit
    assign win_id    = lock_reg ? locked_id_reg : sel_id;
    assign win_vld   = lock_reg ? req_vld[locked_id_reg] : sel_vld;
    assign win_pd    = req_pd[win_id];
    assign win_size  = win_pd[PW-1:AW];
    assign win_need  = {1'b0, win_size} + NW'(1);
    assign credit_ok = MW'(win_need) <= MW'(credit_cnt_reg);
    assign out_free  = ~pvld_reg | dma_rd_req_prdy;
    assign grant     = ~nvdla_core_rst & win_vld & out_free & credit_ok & ~ord_full;

    assign bs_req_prdy = grant & (win_id == ID_BS);
    assign bn_req_prdy = grant & (win_id == ID_BN);
    assign ew_req_prdy = grant & (win_id == ID_EW);

    // Next credit: debit the granted atoms, credit one per returned atom, cap at full
    always_comb begin
        credit_sum = MW'(credit_cnt_reg) + MW'(lat_pop);
        if (grant) begin
            credit_sum = credit_sum - MW'(win_need);
        end
        if (credit_sum > MW'(LAT_DEPTH)) begin
            credit_next = CW'(LAT_DEPTH);
        end else begin
            credit_next = credit_sum[CW-1:0];
        end
    end

    // Single-register output stage toward the DMA
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            pvld_reg <= 1'b0;
            pd_reg   <= '0;
        end else if (grant) begin
            pvld_reg <= 1'b1;
            pd_reg   <= win_pd;
        end else if (dma_rd_req_prdy) begin
            pvld_reg <= 1'b0;
        end
    end

    // Round-robin pointer and winner lock
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            rr_ptr_reg    <= ID_BS;
            lock_reg      <= 1'b0;
            locked_id_reg <= ID_BS;
        end else if (grant) begin
            rr_ptr_reg <= rr_add(win_id, 1);
            lock_reg   <= 1'b0;
        end else if (win_vld && !lock_reg) begin
            lock_reg      <= 1'b1;
            locked_id_reg <= sel_id;
        end
    end

    // Latency-buffer credit counter
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            credit_cnt_reg <= CW'(LAT_DEPTH);
        end else begin
            credit_cnt_reg <= credit_next;
        end
    end

    nv_nvdla_sdp_rdma_ord_fifo #(
        .DEPTH (ORD_DEPTH),
        .DW    (2 + SW)
    ) u_ord_fifo (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .push           (grant),
        .push_pd        ({win_id, win_size}),
        .pop            (ord_prdy),
        .pop_pd         (ord_pd),
        .full           (ord_full),
        .empty          (ord_empty)
    );

    assign dma_rd_req_pvld = pvld_reg;
    assign dma_rd_req_pd   = pd_reg;
    assign ord_pvld        = ~ord_empty;
    assign credit_cnt      = credit_cnt_reg;

    // A locked requester must keep its request up until it is granted
    a_lock_hold: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        lock_reg |-> req_vld[locked_id_reg]);

    // Returning an atom while all credit is already free is an upstream error
    a_pop_full: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        lat_pop |-> (credit_cnt_reg != CW'(LAT_DEPTH)));

    // A request larger than the whole latency buffer could never be granted
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_size_chk
        a_size_fits: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
            req_vld[gi] |-> (MW'(req_pd[gi][PW-1:AW]) < MW'(LAT_DEPTH)));
    end

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_req_arb.sv
// Bench for the SDP RDMA request arbiter: directed scenarios, expected DMA
// requests and order entries queued at grant time, compared on hand-off.
module tb_nv_nvdla_sdp_rdma_req_arb;
    import nv_nvdla_sdp_rdma_pkg::*;

    localparam int LAT_DEPTH = 256;
    localparam int ORD_DEPTH = 16;
    localparam int AW = 64;
    localparam int SW = 15;
    localparam int PW = AW + SW;
    localparam int OW = 2 + SW;
    localparam int CW = $clog2(LAT_DEPTH + 1);

    localparam logic [2:0] P_NONE = 3'b000;
    localparam logic [2:0] P_BS   = 3'b001;
    localparam logic [2:0] P_BN   = 3'b010;
    localparam logic [2:0] P_EW   = 3'b100;

    logic          nvdla_core_clk = 1'b0;
    logic          nvdla_core_rst;
    logic          bs_req_pvld, bn_req_pvld, ew_req_pvld;
    logic          bs_req_prdy, bn_req_prdy, ew_req_prdy;
    logic [PW-1:0] bs_req_pd, bn_req_pd, ew_req_pd;
    logic          dma_rd_req_pvld;
    logic          dma_rd_req_prdy;
    logic [PW-1:0] dma_rd_req_pd;
    logic          lat_pop;
    logic          ord_pvld;
    logic          ord_prdy;
    logic [OW-1:0] ord_pd;
    logic [CW-1:0] credit_cnt;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    nv_nvdla_sdp_rdma_req_arb #(
        .LAT_DEPTH (LAT_DEPTH),
        .ORD_DEPTH (ORD_DEPTH),
        .AW        (AW),
        .SW        (SW)
    ) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rst  (nvdla_core_rst),
        .bs_req_pvld     (bs_req_pvld),
        .bs_req_prdy     (bs_req_prdy),
        .bs_req_pd       (bs_req_pd),
        .bn_req_pvld     (bn_req_pvld),
        .bn_req_prdy     (bn_req_prdy),
        .bn_req_pd       (bn_req_pd),
        .ew_req_pvld     (ew_req_pvld),
        .ew_req_prdy     (ew_req_prdy),
        .ew_req_pd       (ew_req_pd),
        .dma_rd_req_pvld (dma_rd_req_pvld),
        .dma_rd_req_prdy (dma_rd_req_prdy),
        .dma_rd_req_pd   (dma_rd_req_pd),
        .lat_pop         (lat_pop),
        .ord_pvld        (ord_pvld),
        .ord_prdy        (ord_prdy),
        .ord_pd          (ord_pd),
        .credit_cnt      (credit_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [PW-1:0] exp_dma_q[$];
    logic [OW-1:0] exp_ord_q[$];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [PW-1:0] mk_pd(input int size, input longint addr);
        rdma_req_pd_t p;
        p.size = SW'(size);
        p.addr = AW'(addr);
        return p;
    endfunction

    function automatic logic [OW-1:0] mk_ord(input logic [1:0] id, input int size);
        rdma_ord_pd_t o;
        o.id   = id;
        o.size = SW'(size);
        return o;
    endfunction

    task automatic tick();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge nvdla_core_clk);
    endtask

    task automatic check_prdy(input string tag, input logic [2:0] exp);
        check_val(tag, 128'({ew_req_prdy, bn_req_prdy, bs_req_prdy}), 128'(exp));
    endtask

    // Record the expected DMA request and order entry for a grant
    task automatic expect_grant(input logic [1:0] id, input logic [PW-1:0] pd);
        rdma_req_pd_t p;
        p = pd;
        exp_dma_q.push_back(pd);
        exp_ord_q.push_back(mk_ord(id, int'(p.size)));
    endtask

    task automatic do_reset();
        bs_req_pvld = 0; bn_req_pvld = 0; ew_req_pvld = 0;
        lat_pop = 0; ord_prdy = 0; dma_rd_req_prdy = 0;
        nvdla_core_rst = 1;
        tick();
        tick();
        exp_dma_q.delete();
        exp_ord_q.delete();
        nvdla_core_rst = 0;
    endtask

    // Accept everything outstanding and make sure the scoreboard empties
    task automatic drain(input string tag);
        dma_rd_req_prdy = 1;
        ord_prdy = 1;
        for (int i = 0; i < 100 && (exp_dma_q.size() != 0 || exp_ord_q.size() != 0); i++) tick();
        tick();
        check_val({tag, "_dma_left"}, 128'(exp_dma_q.size()), 128'(0));
        check_val({tag, "_ord_left"}, 128'(exp_ord_q.size()), 128'(0));
        at_neg();
        check_val({tag, "_ord_pvld_end"}, 128'(ord_pvld), 128'(0));
        tick();
        ord_prdy = 0;
    endtask

    // Scoreboard: compare every DMA hand-off and every order-FIFO pop
    always @(negedge nvdla_core_clk) begin
        if (!nvdla_core_rst) begin
            if (dma_rd_req_pvld && dma_rd_req_prdy) begin
                if (exp_dma_q.size() == 0) check_val("dma_extra", 128'(exp_dma_q.size()), 128'(1));
                else check_val("dma_pd", 128'(dma_rd_req_pd), 128'(exp_dma_q.pop_front()));
            end
            if (ord_pvld && ord_prdy) begin
                if (exp_ord_q.size() == 0) check_val("ord_extra", 128'(exp_ord_q.size()), 128'(1));
                else check_val("ord_pd", 128'(ord_pd), 128'(exp_ord_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        nvdla_core_rst = 1;
        bs_req_pvld = 1; bn_req_pvld = 0; ew_req_pvld = 0;
        bs_req_pd = mk_pd(0, 'h100); bn_req_pd = '0; ew_req_pd = '0;
        dma_rd_req_prdy = 1; lat_pop = 0; ord_prdy = 0;
        tick(); tick(); tick();
        at_neg();
        check_val("rst_dma_pvld", 128'(dma_rd_req_pvld), 128'(0));
        check_val("rst_dma_pd", 128'(dma_rd_req_pd), 128'(0));
        check_prdy("rst_prdy", P_NONE);
        check_val("rst_ord_pvld", 128'(ord_pvld), 128'(0));
        check_val("rst_credit", 128'(credit_cnt), 128'(256));
        tick();
        nvdla_core_rst = 0;
        bs_req_pvld = 0;

        // ---------------- 1: round robin, 1-atom requests ----------------
        bs_req_pd = mk_pd(0, 'h1000);
        bn_req_pd = mk_pd(0, 'h2000);
        ew_req_pd = mk_pd(0, 'h3000);
        bs_req_pvld = 1; bn_req_pvld = 1; ew_req_pvld = 1;
        dma_rd_req_prdy = 1;
        begin
            logic [2:0] exp_p [4];
            logic [1:0] exp_id [4];
            exp_p  = '{P_BS, P_BN, P_EW, P_BS};
            exp_id = '{ID_BS, ID_BN, ID_EW, ID_BS};
            for (int k = 0; k < 4; k++) begin
                at_neg();
                check_prdy("t1_rr_prdy", exp_p[k]);
                case (exp_id[k])
                    ID_BS:   expect_grant(ID_BS, bs_req_pd);
                    ID_BN:   expect_grant(ID_BN, bn_req_pd);
                    default: expect_grant(ID_EW, ew_req_pd);
                endcase
                tick();
            end
        end
        bs_req_pvld = 0; bn_req_pvld = 0; ew_req_pvld = 0;
        at_neg();
        check_val("t1_credit", 128'(credit_cnt), 128'(252));
        tick();
        drain("t1");

        // ---------------- 2: credit stall and lock ----------------
        do_reset();
        dma_rd_req_prdy = 1;
        bs_req_pd = mk_pd(199, 'hA000);
        bn_req_pd = mk_pd(99, 'hB000);
        ew_req_pd = mk_pd(0, 'hC000);
        bs_req_pvld = 1; bn_req_pvld = 1; ew_req_pvld = 1;
        at_neg();
        check_prdy("t2_bs_grant", P_BS);
        expect_grant(ID_BS, bs_req_pd);
        tick();
        bs_req_pvld = 0;
        lat_pop = 1;
        at_neg();
        check_val("t2_credit_56", 128'(credit_cnt), 128'(56));
        check_prdy("t2_bn_stall", P_NONE);
        tick();
        for (int i = 1; i < 44; i++) begin
            at_neg();
            check_prdy("t2_stall_ew_blocked", P_NONE);
            tick();
        end
        lat_pop = 0;
        at_neg();
        check_val("t2_credit_100", 128'(credit_cnt), 128'(100));
        check_prdy("t2_bn_grant", P_BN);
        expect_grant(ID_BN, bn_req_pd);
        tick();
        bn_req_pvld = 0;
        at_neg();
        check_val("t2_credit_0", 128'(credit_cnt), 128'(0));
        check_prdy("t2_ew_no_credit", P_NONE);
        lat_pop = 1;
        tick();
        lat_pop = 0;
        at_neg();
        check_prdy("t2_ew_grant", P_EW);
        expect_grant(ID_EW, ew_req_pd);
        tick();
        ew_req_pvld = 0;
        at_neg();
        check_val("t2_credit_end", 128'(credit_cnt), 128'(0));
        tick();
        drain("t2");

        // ---------------- 3: DMA back-pressure ----------------
        do_reset();
        dma_rd_req_prdy = 0;
        bs_req_pd = mk_pd(0, 'h5000);
        bs_req_pvld = 1;
        at_neg();
        check_prdy("t3_bs_grant", P_BS);
        expect_grant(ID_BS, bs_req_pd);
        tick();
        bs_req_pvld = 0;
        bn_req_pd = mk_pd(2, 'h6000);
        bn_req_pvld = 1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check_prdy("t3_bp_prdy", P_NONE);
            check_val("t3_bp_pd_stable", 128'(dma_rd_req_pd), 128'(mk_pd(0, 'h5000)));
            check_val("t3_bp_pvld", 128'(dma_rd_req_pvld), 128'(1));
            tick();
        end
        dma_rd_req_prdy = 1;
        at_neg();
        check_prdy("t3_release_grant", P_BN);
        expect_grant(ID_BN, bn_req_pd);
        tick();
        bn_req_pvld = 0;
        at_neg();
        check_val("t3_credit", 128'(credit_cnt), 128'(252));
        tick();
        drain("t3");

        // ---------------- 4: order FIFO full ----------------
        do_reset();
        dma_rd_req_prdy = 1;
        ord_prdy = 0;
        bs_req_pvld = 1;
        for (int i = 0; i < 16; i++) begin
            bs_req_pd = mk_pd(i % 4, 'h10000 + i);
            at_neg();
            check_prdy("t4_fill", P_BS);
            expect_grant(ID_BS, bs_req_pd);
            tick();
        end
        bs_req_pd = mk_pd(1, 'h20000);
        at_neg();
        check_prdy("t4_full_block", P_NONE);
        check_val("t4_credit_held", 128'(credit_cnt), 128'(216));
        tick();
        ord_prdy = 1;
        at_neg();
        check_prdy("t4_pop_cycle", P_NONE);
        tick();
        ord_prdy = 0;
        at_neg();
        check_prdy("t4_after_pop", P_BS);
        expect_grant(ID_BS, bs_req_pd);
        tick();
        bs_req_pvld = 0;
        at_neg();
        check_val("t4_credit", 128'(credit_cnt), 128'(214));
        tick();
        drain("t4");

        // ---------------- 5: grant and pop together ----------------
        do_reset();
        dma_rd_req_prdy = 1;
        bs_req_pd = mk_pd(245, 'h7000);
        bs_req_pvld = 1;
        at_neg();
        check_prdy("t5_big_grant", P_BS);
        expect_grant(ID_BS, bs_req_pd);
        tick();
        bs_req_pd = mk_pd(3, 'h7100);
        lat_pop = 1;
        at_neg();
        check_val("t5_credit_10", 128'(credit_cnt), 128'(10));
        check_prdy("t5_small_grant", P_BS);
        expect_grant(ID_BS, bs_req_pd);
        tick();
        bs_req_pvld = 0;
        lat_pop = 0;
        at_neg();
        check_val("t5_credit_7", 128'(credit_cnt), 128'(7));
        tick();
        drain("t5");

        // ---------------- 6: reset mid-stream ----------------
        do_reset();
        dma_rd_req_prdy = 1;
        ord_prdy = 0;
        bs_req_pvld = 1;
        for (int i = 0; i < 5; i++) begin
            bs_req_pd = mk_pd(0, 'h8000 + i);
            at_neg();
            check_prdy("t6_pre", P_BS);
            expect_grant(ID_BS, bs_req_pd);
            tick();
        end
        bs_req_pvld = 0;
        dma_rd_req_prdy = 0;
        at_neg();
        check_val("t6_pvld_before", 128'(dma_rd_req_pvld), 128'(1));
        check_val("t6_ord_before", 128'(ord_pvld), 128'(1));
        nvdla_core_rst = 1;
        exp_dma_q.delete();
        exp_ord_q.delete();
        tick();
        at_neg();
        check_val("t6_pvld_after", 128'(dma_rd_req_pvld), 128'(0));
        check_val("t6_ord_after", 128'(ord_pvld), 128'(0));
        check_val("t6_credit_after", 128'(credit_cnt), 128'(256));
        tick();
        nvdla_core_rst = 0;
        dma_rd_req_prdy = 1;
        bs_req_pd = mk_pd(0, 'h9000);
        bn_req_pd = mk_pd(0, 'h9100);
        ew_req_pd = mk_pd(0, 'h9200);
        bs_req_pvld = 1; bn_req_pvld = 1; ew_req_pvld = 1;
        at_neg();
        check_prdy("t6_first_grant", P_BS);
        expect_grant(ID_BS, bs_req_pd);
        tick();
        bs_req_pvld = 0; bn_req_pvld = 0; ew_req_pvld = 0;
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
